// File: rtl/hwag_coil_sched.sv
// Multi-channel ignition coil scheduler driven by the interpolated crank angle.
// Optional per-channel dwell time limit: define HWAG_COIL_DWELL_LIMIT_EN.
module hwag_coil_sched #(
  parameter int unsigned ACNT_WIDTH = 24,
  parameter int unsigned CHANNELS   = 4,
  parameter int unsigned MAX_ANGLE  = 3839,
  parameter int unsigned DWELL_MAX  = 500000
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        sync,
  input  logic [ACNT_WIDTH-1:0]       acnt,
  input  logic                        wr_ena,
  input  logic [$clog2(CHANNELS):0]   wr_addr,
  input  logic [ACNT_WIDTH-1:0]       wr_data,
  output logic                        wr_err,
  output logic [CHANNELS-1:0]         pending,
  output logic [CHANNELS-1:0]         coil_out,
  output logic [CHANNELS-1:0]         fault_out
);

  localparam int unsigned CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  typedef enum logic {
    OFF   = 1'b0,
    DWELL = 1'b1
  } coil_state_e;

  logic [ACNT_WIDTH-1:0] acnt_prev;
  logic [ACNT_WIDTH-1:0] set_sh    [CHANNELS];
  logic [ACNT_WIDTH-1:0] rst_sh    [CHANNELS];
  logic [ACNT_WIDTH-1:0] set_act   [CHANNELS];
  logic [ACNT_WIDTH-1:0] rst_act   [CHANNELS];
  logic [ACNT_WIDTH-1:0] set_eff_c [CHANNELS];
  logic [ACNT_WIDTH-1:0] rst_eff_c [CHANNELS];
  coil_state_e           state_q   [CHANNELS];
  coil_state_e           state_d   [CHANNELS];

  logic                  step_c;
  logic                  wrap_c;
  logic                  wr_ok_c;
  logic [CH_W-1:0]       wr_ch;
  logic                  wr_sel;
  logic [CHANNELS-1:0]   wr_hit_c;
  logic [CHANNELS-1:0]   limit_c;

  // A held angle is not an event; every angle event is qualified by a change.
  assign step_c  = sync & (acnt != acnt_prev);
  assign wrap_c  = step_c & (acnt == '0);
  assign wr_ch   = CH_W'(wr_addr >> 1);
  assign wr_sel  = wr_addr[0];
  assign wr_ok_c = wr_ena & (wr_data <= ACNT_WIDTH'(MAX_ANGLE)) & (32'(wr_ch) < CHANNELS);

  always_comb begin
    wr_hit_c = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      wr_hit_c[i] = wr_ok_c & (wr_ch == CH_W'(i));
    end
  end

  // Host shadow registers, wrap-time load into active, pending flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acnt_prev <= '0;
      wr_err    <= 1'b0;
      pending   <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        set_sh[i]  <= '0;
        rst_sh[i]  <= '0;
        set_act[i] <= '0;
        rst_act[i] <= '0;
      end
    end else begin
      acnt_prev <= acnt;
      wr_err    <= wr_ena & ~wr_ok_c;
      for (int i = 0; i < CHANNELS; i++) begin
        if (wrap_c && pending[i]) begin
          set_act[i] <= set_sh[i];
          rst_act[i] <= rst_sh[i];
        end
        if (wr_hit_c[i]) begin
          if (wr_sel) rst_sh[i] <= wr_data;
          else        set_sh[i] <= wr_data;
        end
        // A write coincident with wrap stays pending for the following wrap.
        pending[i] <= (pending[i] & ~wrap_c) | wr_hit_c[i];
      end
    end
  end

  // Events on a load cycle compare against the values being loaded.
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      set_eff_c[i] = set_act[i];
      rst_eff_c[i] = rst_act[i];
      if (wrap_c && pending[i]) begin
        set_eff_c[i] = set_sh[i];
        rst_eff_c[i] = rst_sh[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < CHANNELS; i++) state_q[i] <= OFF;
    end else begin
      for (int i = 0; i < CHANNELS; i++) state_q[i] <= state_d[i];
    end
  end

  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      state_d[i] = state_q[i];
      if (!sync) begin
        state_d[i] = OFF;
      end else begin
        case (state_q[i])
          OFF: begin
            if (step_c && (acnt == set_eff_c[i]) && (set_eff_c[i] != rst_eff_c[i]))
              state_d[i] = DWELL;
          end
          DWELL: begin
            if ((step_c && (acnt == rst_eff_c[i])) || limit_c[i])
              state_d[i] = OFF;
          end
          default: state_d[i] = OFF;
        endcase
      end
    end
  end

  always_comb begin
    coil_out = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      coil_out[i] = (state_q[i] == DWELL);
    end
  end

`ifdef HWAG_COIL_DWELL_LIMIT_EN
  localparam int unsigned CNT_W = $clog2(DWELL_MAX + 1);

  logic [CNT_W-1:0]    dwell_cnt [CHANNELS];
  logic [CHANNELS-1:0] fault_q;

  // Limit fires in the DWELL_MAX-th cycle of dwell, so the coil is high for exactly DWELL_MAX clocks.
  always_comb begin
    limit_c = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      limit_c[i] = (state_q[i] == DWELL) && (dwell_cnt[i] == CNT_W'(DWELL_MAX - 1));
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fault_q <= '0;
      for (int i = 0; i < CHANNELS; i++) dwell_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if ((state_q[i] == DWELL) && (state_d[i] == DWELL))
          dwell_cnt[i] <= dwell_cnt[i] + CNT_W'(1);
        else
          dwell_cnt[i] <= '0;
        if (limit_c[i])
          fault_q[i] <= 1'b1;
        else if (wr_hit_c[i])
          fault_q[i] <= 1'b0;
      end
    end
  end

  assign fault_out = fault_q;
`else
  assign limit_c   = '0;
  assign fault_out = '0;
`endif

endmodule

// File: tb/tb_hwag_coil_sched.sv
// Directed bench for hwag_coil_sched: vector table plus hand-written corner sequences.
module tb_hwag_coil_sched;

  localparam int unsigned AW = 24;
  localparam int unsigned NC = 4;
`ifdef HWAG_COIL_DWELL_LIMIT_EN
  localparam bit LIMIT_EN = 1'b1;
`else
  localparam bit LIMIT_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          sync;
  logic [AW-1:0] acnt;
  logic          wr_ena;
  logic [2:0]    wr_addr;
  logic [AW-1:0] wr_data;
  logic          wr_err;
  logic [NC-1:0] pending;
  logic [NC-1:0] coil_out;
  logic [NC-1:0] fault_out;

  int n_checks = 0;
  int n_pass   = 0;

  hwag_coil_sched #(
    .ACNT_WIDTH(AW), .CHANNELS(NC), .MAX_ANGLE(3839), .DWELL_MAX(1000)
  ) dut (
    .clk(clk), .rst(rst), .sync(sync), .acnt(acnt),
    .wr_ena(wr_ena), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_err(wr_err), .pending(pending), .coil_out(coil_out), .fault_out(fault_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] acnt;
    logic          wr;
    logic [2:0]    addr;
    logic [AW-1:0] data;
    logic [NC-1:0] coil;
    logic [NC-1:0] pend;
    logic          err;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input int a, input bit wr, input logic [2:0] ad, input int d,
                     input logic [3:0] c, input logic [3:0] p, input bit e);
    vec_t v;
    v.acnt = AW'(a); v.wr = wr; v.addr = ad; v.data = AW'(d);
    v.coil = c; v.pend = p; v.err = e;
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic go(input int a);
    acnt = AW'(a);
    tick();
  endtask

  task automatic wr(input logic [2:0] ad, input int d);
    wr_ena = 1'b1; wr_addr = ad; wr_data = AW'(d);
    tick();
    wr_ena = 1'b0;
  endtask

  initial begin
    logic [3:0] exp_c;
    rst = 1'b0; sync = 1'b0; acnt = '0; wr_ena = 1'b0; wr_addr = '0; wr_data = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_coil", 32'(coil_out), 0);
    chk("reset_pending", 32'(pending), 0);
    chk("reset_wr_err", 32'(wr_err), 0);
    chk("reset_fault", 32'(fault_out), 0);
    rst = 1'b1;
    tick();

    // acnt, wr, addr, data, coil, pending, wr_err
    add(100,  1, 3'b000, 32,   4'b0000, 4'b0001, 0);
    add(100,  1, 3'b001, 96,   4'b0000, 4'b0001, 0);
    add(3839, 0, 3'b000, 0,    4'b0000, 4'b0001, 0);
    add(0,    0, 3'b000, 0,    4'b0000, 4'b0000, 0);
    add(31,   0, 3'b000, 0,    4'b0000, 4'b0000, 0);
    add(32,   0, 3'b000, 0,    4'b0001, 4'b0000, 0);
    add(33,   0, 3'b000, 0,    4'b0001, 4'b0000, 0);
    add(95,   0, 3'b000, 0,    4'b0001, 4'b0000, 0);
    add(96,   0, 3'b000, 0,    4'b0000, 4'b0000, 0);
    add(97,   0, 3'b000, 0,    4'b0000, 4'b0000, 0);
    add(97,   1, 3'b010, 3840, 4'b0000, 4'b0000, 1);
    add(97,   0, 3'b000, 0,    4'b0000, 4'b0000, 0);
    add(3839, 0, 3'b000, 0,    4'b0000, 4'b0000, 0);
    add(0,    0, 3'b000, 0,    4'b0000, 4'b0000, 0);
    add(32,   0, 3'b000, 0,    4'b0001, 4'b0000, 0);
    add(50,   1, 3'b001, 200,  4'b0001, 4'b0001, 0);
    add(96,   0, 3'b000, 0,    4'b0000, 4'b0001, 0);
    add(150,  0, 3'b000, 0,    4'b0000, 4'b0001, 0);
    add(3839, 0, 3'b000, 0,    4'b0000, 4'b0001, 0);
    add(0,    0, 3'b000, 0,    4'b0000, 4'b0000, 0);
    add(32,   0, 3'b000, 0,    4'b0001, 4'b0000, 0);
    add(96,   0, 3'b000, 0,    4'b0001, 4'b0000, 0);
    add(199,  0, 3'b000, 0,    4'b0001, 4'b0000, 0);
    add(200,  0, 3'b000, 0,    4'b0000, 4'b0000, 0);
    add(3839, 0, 3'b000, 0,    4'b0000, 4'b0000, 0);
    add(0,    1, 3'b001, 120,  4'b0000, 4'b0001, 0);
    add(32,   0, 3'b000, 0,    4'b0001, 4'b0001, 0);
    add(120,  0, 3'b000, 0,    4'b0001, 4'b0001, 0);
    add(200,  0, 3'b000, 0,    4'b0000, 4'b0001, 0);
    add(3839, 0, 3'b000, 0,    4'b0000, 4'b0001, 0);
    add(0,    0, 3'b000, 0,    4'b0000, 4'b0000, 0);
    add(32,   0, 3'b000, 0,    4'b0001, 4'b0000, 0);
    add(120,  0, 3'b000, 0,    4'b0000, 4'b0000, 0);
    add(500,  1, 3'b100, 0,    4'b0000, 4'b0100, 0);
    add(500,  1, 3'b101, 10,   4'b0000, 4'b0100, 0);
    add(3839, 0, 3'b000, 0,    4'b0000, 4'b0100, 0);
    add(0,    0, 3'b000, 0,    4'b0100, 4'b0000, 0);
    add(5,    0, 3'b000, 0,    4'b0100, 4'b0000, 0);
    add(10,   0, 3'b000, 0,    4'b0000, 4'b0000, 0);
    add(11,   1, 3'b110, 100,  4'b0000, 4'b1000, 0);
    add(11,   1, 3'b111, 100,  4'b0000, 4'b1000, 0);
    add(3839, 0, 3'b000, 0,    4'b0000, 4'b1000, 0);
    add(0,    0, 3'b000, 0,    4'b0100, 4'b0000, 0);
    add(10,   0, 3'b000, 0,    4'b0000, 4'b0000, 0);
    add(100,  0, 3'b000, 0,    4'b0000, 4'b0000, 0);
    add(101,  0, 3'b000, 0,    4'b0000, 4'b0000, 0);
    add(101,  1, 3'b011, 3839, 4'b0000, 4'b0010, 0);

    sync = 1'b1;
    foreach (tbl[k]) begin
      acnt = tbl[k].acnt; wr_ena = tbl[k].wr; wr_addr = tbl[k].addr; wr_data = tbl[k].data;
      tick();
      wr_ena = 1'b0;
      chk($sformatf("vec%0d_coil", k), 32'(coil_out), 32'(tbl[k].coil));
      chk($sformatf("vec%0d_pending", k), 32'(pending), 32'(tbl[k].pend));
      chk($sformatf("vec%0d_wr_err", k), 32'(wr_err), 32'(tbl[k].err));
    end

    // Wrap-around dwell on ch1 (3800 -> 40) alongside ch0 (32..120) and ch2 (0..10).
    wr(3'b010, 3800);
    wr(3'b011, 40);
    for (int a = 102; a <= 3839; a++) go(a);
    go(0);
    chk("wrap_load_pending", 32'(pending), 0);
    chk("wrap_load_coil", 32'(coil_out), 32'h4);
    for (int pass = 0; pass < 2; pass++) begin
      for (int a = (pass == 0) ? 1 : 0; a <= ((pass == 0) ? 3839 : 60); a++) begin
        go(a);
        exp_c[0] = (a >= 32) && (a < 120);
        exp_c[1] = (pass == 0) ? (a >= 3800) : (a < 40);
        exp_c[2] = (a < 10);
        exp_c[3] = 1'b0;
        chk($sformatf("wrap_dwell_p%0d_a%0d", pass, a), 32'(coil_out), 32'(exp_c));
      end
    end

    // sync drop mid-dwell, re-sync on a held angle, then retained active angles.
    sync = 1'b0; go(61);
    chk("sync_drop_coil", 32'(coil_out), 0);
    go(32);
    sync = 1'b1; go(32);
    chk("sync_rise_held", 32'(coil_out), 0);
    go(33);
    chk("sync_rise_next", 32'(coil_out), 0);
    go(3839); go(0);
    chk("retained_ch2", 32'(coil_out), 32'h4);
    go(10); go(31); go(32);
    chk("retained_ch0", 32'(coil_out), 32'h1);

    // Asynchronous reset mid-dwell with a pending write outstanding.
    wr(3'b110, 5);
    chk("pre_reset_pending", 32'(pending), 32'h8);
    #2 rst = 1'b0;
    #1;
    chk("async_reset_coil", 32'(coil_out), 0);
    chk("async_reset_pending", 32'(pending), 0);
    #2 rst = 1'b1;
    tick();
    go(3839); go(0); go(31); go(32);
    chk("reset_cleared_active", 32'(coil_out), 0);

    // Dwell time limit with acnt parked inside the dwell window.
    wr(3'b000, 32);
    wr(3'b001, 96);
    go(3839); go(0); go(31); go(32);
    chk("limit_start", 32'(coil_out), 32'h1);
    acnt = AW'(33);
    for (int n = 1; n <= 1200; n++) begin
      tick();
      if (n == 999)  chk("limit_n999_coil", 32'(coil_out[0]), 1);
      if (n == 1000) begin
        chk("limit_n1000_coil", 32'(coil_out[0]), LIMIT_EN ? 0 : 1);
        chk("limit_n1000_fault", 32'(fault_out), LIMIT_EN ? 1 : 0);
      end
      if (n == 1200) begin
        chk("limit_n1200_coil", 32'(coil_out[0]), LIMIT_EN ? 0 : 1);
        chk("limit_n1200_fault", 32'(fault_out), LIMIT_EN ? 1 : 0);
      end
    end
    wr(3'b001, 96);
    chk("fault_cleared_by_write", 32'(fault_out), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/hwag_coil_sched.md
Name: hwag_coil_sched

Overview:
- Multi-channel ignition coil scheduler that sits directly downstream of the angle generator.
- Consumes the interpolated crank angle (acnt2 domain, 0..MAX_ANGLE) and the generator-running flag.
- Drives CHANNELS coil outputs, each on from its own set angle to its own reset angle.
- Angles are written by the host into shadow registers and take effect only at the angle wrap to 0, so a dwell is never torn mid-cycle.

Parameters:
- ACNT_WIDTH, 24: width of the angle bus and of the set/reset angle registers.
- CHANNELS, 4: number of coil channels (1..8).
- MAX_ANGLE, 3839: highest legal angle; angle counter top.
- DWELL_MAX, 500000: dwell limit in clk cycles; used only with the optional feature.

Ports:
- clk, input, 1: system clock, all logic on the rising edge.
- rst, input, 1: asynchronous, active-low reset.
- sync, input, 1: angle generator running and synchronised (hwag_start); low means the angle is invalid.
- acnt, input, ACNT_WIDTH: current crank angle.
- wr_ena, input, 1: single-cycle shadow-register write strobe.
- wr_addr, input, clog2(CHANNELS)+1: {channel, sel}; sel=0 selects the set angle, sel=1 the reset angle.
- wr_data, input, ACNT_WIDTH: angle to write.
- wr_err, output, 1: one-cycle pulse when a write is rejected.
- pending, output, CHANNELS: shadow written but not yet loaded into active, per channel.
- coil_out, output, CHANNELS: coil drive, 1 = dwell (charging).
- fault_out, output, CHANNELS: sticky dwell-limit fault per channel.

Behaviour:
- Reset (rst=0): all shadow, active and acnt_prev registers = 0; pending = 0; coil_out = 0; fault_out = 0; wr_err = 0. Asynchronous assert, synchronous deassert assumed upstream.
- Step detect: acnt_prev <= acnt every clk. step = sync & (acnt != acnt_prev). All angle events are qualified by step, so a held angle fires once only.
- Wrap: wrap = step & (acnt == 0).
  - On wrap, every channel with pending=1 copies shadow set/reset into active and clears pending.
- Write: wr_ena with wr_data <= MAX_ANGLE writes the addressed shadow register and sets pending[ch] next clk.
  - wr_data > MAX_ANGLE: no register change; wr_err pulses 1 next clk.
  - Write on the same clk as wrap: wrap loads the pre-write shadow; the new value stays pending for the next wrap.
- Per-channel FSM, two states:
  - OFF (coil 0) -> DWELL on step & acnt == set_act & set_act != reset_act.
  - DWELL (coil 1) -> OFF on step & acnt == reset_act.
  - set_act == reset_act: channel disabled, held in OFF.
- Wrap-around dwell: set_act > reset_act is legal; dwell spans angle 0. Equality events handle it with no special case.
- Event and load on the same clk: a load on wrap does not change the current state. Events on that clk compare against the newly loaded active values.
- Latency: coil_out is registered and changes 1 clk after the qualifying acnt value is presented.
- sync low: all channels go to OFF and coil_out = 0 on the next clk. Shadow, active and pending are retained.
- sync rising: acnt_prev is re-sampled. No event fires until acnt changes.
- acnt is expected to advance by 1 (or jump to 0). A skipped target angle misses its event; this block does no crossing interpolation.

Optional Feature:
- HWAG_COIL_DWELL_LIMIT_EN defined:
  - Each channel has a dwell clock counter, cleared in OFF and incremented in DWELL.
  - When it reaches DWELL_MAX, the channel is forced to OFF and fault_out[ch] is set.
  - fault_out[ch] clears on the next accepted write to that channel.
  - While fault_out[ch]=1, OFF->DWELL is still permitted.
- Not defined: no counters are built; fault_out is tied to 0.

Test Plan:
- Basic dwell: write ch0 set=32, reset=96; ramp acnt 0..3839 with sync=1 -> pending[0] clears at acnt=0; coil_out[0] rises 1 clk after acnt=32 and falls 1 clk after acnt=96; other channels stay 0.
- Wrap dwell: ch1 set=3800, reset=40 -> coil_out[1] is high from 3800 through 3839, 0, up to 40, then low.
- Shadow timing: ch0 in DWELL (set=32, reset=96); at acnt=50 write reset=200 -> coil still falls at 96 this cycle; falls at 200 next cycle. Write coincident with wrap -> takes effect one cycle later.
- Rejects and disables: write 3840 -> wr_err pulses 1 clk, pending unchanged. Set=reset=100 -> coil never asserts.
- sync drop and reset: drop sync while in DWELL -> coil_out=0 next clk. Assert rst mid-dwell -> all outputs 0 immediately, active angles cleared.
- Dwell limit (macro on, DWELL_MAX=1000): hold acnt between set and reset for 1200 clk -> coil falls at clk 1000, fault_out set; next write clears it. Macro off -> coil stays high, fault_out=0.
